// File: rtl/tdm_slot_capture.sv
// tdm_slot_capture
//   Demultiplexes a serial sample lane into four slot registers. The one-hot
//   phase token from the ring counter selects the slot. A completed rotation
//   (slot0..slot3 in order) is delivered as one 4*W-bit frame through a
//   valid/ready output register.
//   Flags: seq_err (bad or out-of-order phase while collecting), overrun
//   (completed frame dropped because the output was full), and drop_cnt
//   (aborted partial frames).
//   Optional feature macro: TDM_FRAME_CNT_EN builds the delivered-frame counter.
//   Without the macro, frame_cnt is tied to zero.
module tdm_slot_capture #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [3:0]       phase,
    input  logic [W-1:0]     din,
    input  logic             din_valid,
    input  logic             err_clr,
    output logic [4*W-1:0]   frame,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             seq_err,
    output logic             overrun,
    output logic [7:0]       drop_cnt,
    output logic [7:0]       frame_cnt
);

    localparam logic ST_SYNC    = 1'b0;
    localparam logic ST_COLLECT = 1'b1;

    logic           r_state;
    logic [1:0]     r_exp;
    logic [W-1:0]   r_slot0;
    logic [W-1:0]   r_slot1;
    logic [W-1:0]   r_slot2;
    logic [4*W-1:0] r_frame;
    logic           r_frame_valid;
    logic           r_seq_err;
    logic           r_overrun;
    logic [7:0]     r_drop_cnt;

    logic [3:0]     w_exp_oh;
    logic           w_match;
    logic           w_start;
    logic           w_take;
    logic           w_abort;
    logic           w_seq_ev;
    logic           w_complete;
    logic           w_xfer;
    logic           w_load;
    logic           w_ovr_ev;

    // Slot decode and the per-cycle event strobes that every register below uses.
    always_comb begin
        w_exp_oh   = 4'b0001 << r_exp;
        w_match    = (phase == w_exp_oh);
        // Only a valid slot0 sample can open a frame. Everything else in SYNC is ignored.
        w_start    = (r_state == ST_SYNC) && (phase == 4'b0001) && din_valid;
        w_take     = (r_state == ST_COLLECT) && w_match && din_valid;
        // While collecting, a missing sample or a bad phase both kill the partial frame.
        w_abort    = (r_state == ST_COLLECT) && !(w_match && din_valid);
        w_seq_ev   = (r_state == ST_COLLECT) && !w_match;
        w_complete = w_take && (r_exp == 2'd3);
        w_xfer     = r_frame_valid && frame_ready;
        // A completed frame may load if the output is empty or drains on this same edge.
        w_load     = w_complete && (!r_frame_valid || frame_ready);
        w_ovr_ev   = w_complete && r_frame_valid && !frame_ready;
    end

    // Frame-lock state and expected-slot pointer.
    // After slot3 the pointer wraps to 0 and stays in COLLECT, so frames can run back-to-back.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state <= ST_SYNC;
            r_exp   <= 2'd0;
        end else if (w_start) begin
            r_state <= ST_COLLECT;
            r_exp   <= 2'd1;
        end else if (w_abort) begin
            r_state <= ST_SYNC;
            r_exp   <= 2'd0;
        end else if (w_take) begin
            r_exp   <= r_exp + 2'd1;
        end
    end

    // Slot capture. Slot3 goes straight into the frame register, so it needs no holding register.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
            r_slot2 <= '0;
        end else if (w_start) begin
            r_slot0 <= din;
        end else if (w_take) begin
            case (r_exp)
                2'd0:    r_slot0 <= din;
                2'd1:    r_slot1 <= din;
                2'd2:    r_slot2 <= din;
                default: ;
            endcase
        end
    end

    // Output register. The frame holds while valid and not accepted, and it is only overwritten by a load.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
        end else if (w_load) begin
            r_frame       <= {din, r_slot2, r_slot1, r_slot0};
            r_frame_valid <= 1'b1;
        end else if (w_xfer) begin
            r_frame_valid <= 1'b0;
        end
    end

    // Sticky flags. A new event in the same cycle wins over err_clr.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_seq_err <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_seq_ev)
                r_seq_err <= 1'b1;
            else if (err_clr)
                r_seq_err <= 1'b0;
            if (w_ovr_ev)
                r_overrun <= 1'b1;
            else if (err_clr)
                r_overrun <= 1'b0;
        end
    end

    // Aborted-frame counter. It wraps naturally and is not cleared by err_clr.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear)
            r_drop_cnt <= 8'd0;
        else if (w_abort)
            r_drop_cnt <= r_drop_cnt + 8'd1;
    end

`ifdef TDM_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    // Delivered-frame counter: one count per output transfer, wrapping at 255.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear)
            r_frame_cnt <= 8'd0;
        else if (w_xfer)
            r_frame_cnt <= r_frame_cnt + 8'd1;
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = 8'd0;
`endif

    assign frame       = r_frame;
    assign frame_valid = r_frame_valid;
    assign seq_err     = r_seq_err;
    assign overrun     = r_overrun;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_tdm_slot_capture.sv
// tb_tdm_slot_capture
//   Table-driven directed vectors, a hand-written asynchronous-clear sequence,
//   and a randomized run checked against a queue-based frame assembly model.
module tb_tdm_slot_capture;

    logic        clk;
    logic        clear;
    logic [3:0]  phase;
    logic [7:0]  din;
    logic        din_valid;
    logic        err_clr;
    logic [31:0] frame;
    logic        frame_valid;
    logic        frame_ready;
    logic        seq_err;
    logic        overrun;
    logic [7:0]  drop_cnt;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;

    tdm_slot_capture #(.W(8)) dut (
        .clk(clk), .clear(clear), .phase(phase), .din(din), .din_valid(din_valid),
        .err_clr(err_clr), .frame(frame), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .seq_err(seq_err), .overrun(overrun),
        .drop_cnt(drop_cnt), .frame_cnt(frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a frame is a list of samples that grows in rotation order.
    bit          m_lock;
    logic [7:0]  m_q[$];
    logic [31:0] m_frame;
    bit          m_fv, m_se, m_ov;
    logic [7:0]  m_drop, m_fc;

    task automatic mdl_reset();
        m_lock = 0; m_q.delete(); m_frame = '0;
        m_fv = 0; m_se = 0; m_ov = 0; m_drop = '0; m_fc = '0;
    endtask

    // Apply one clock edge's worth of rules using the inputs present at that edge.
    task automatic mdl_step();
        bit          xfer, complete, bad, abort;
        logic [31:0] newf;
        xfer = m_fv && frame_ready;
        complete = 0; bad = 0; abort = 0; newf = '0;
        if (!m_lock) begin
            if (phase == 4'b0001 && din_valid) begin
                m_q.delete(); m_q.push_back(din); m_lock = 1;
            end
        end else begin
            if (phase != (4'b0001 << m_q.size())) begin
                bad = 1; abort = 1;
            end else if (!din_valid) begin
                abort = 1;
            end else begin
                m_q.push_back(din);
                if (m_q.size() == 4) begin
                    complete = 1;
                    newf = {m_q[3], m_q[2], m_q[1], m_q[0]};
                    m_q.delete();
                end
            end
        end
        if (abort) begin
            m_drop = m_drop + 8'd1; m_lock = 0; m_q.delete();
        end
        if (bad) m_se = 1; else if (err_clr) m_se = 0;
        if (complete && m_fv && !frame_ready) m_ov = 1; else if (err_clr) m_ov = 0;
        if (xfer) m_fc = m_fc + 8'd1;
        if (complete && (!m_fv || frame_ready)) begin
            m_frame = newf; m_fv = 1;
        end else if (xfer) begin
            m_fv = 0;
        end
    endtask

    function automatic logic [7:0] fc_exp(logic [7:0] v);
`ifdef TDM_FRAME_CNT_EN
        return v;
`else
        return 8'd0 & v;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " frame"},     frame,       m_frame);
        chk({tag, " fv"},        frame_valid, 32'(m_fv));
        chk({tag, " seq_err"},   seq_err,     32'(m_se));
        chk({tag, " overrun"},   overrun,     32'(m_ov));
        chk({tag, " drop_cnt"},  drop_cnt,    m_drop);
        chk({tag, " frame_cnt"}, frame_cnt,   fc_exp(m_fc));
    endtask

    task automatic do_reset();
        @(negedge clk);
        phase = '0; din = '0; din_valid = 0; err_clr = 0; frame_ready = 0;
        clear = 0;
        #2 clear = 1;
        mdl_reset();
    endtask

    // Drive, take one edge, update the model, and leave the outputs settled (#1 after the edge).
    task automatic step(input logic [3:0] ph, input logic [7:0] d, input logic v,
                        input logic rdy, input logic clr);
        phase = ph; din = d; din_valid = v; frame_ready = rdy; err_clr = clr;
        @(posedge clk);
        mdl_step();
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  ph;
        logic [7:0]  din;
        logic        v, rdy, clr;
        logic [31:0] frame;
        logic        fv, se, ov;
        logic [7:0]  drop, fc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [3:0] ph, logic [7:0] d, logic v, logic rdy,
                                logic clr, logic [31:0] f, logic fv, logic se, logic ov,
                                logic [7:0] dr, logic [7:0] fc);
        vec_t r;
        r.rst = rst; r.ph = ph; r.din = d; r.v = v; r.rdy = rdy; r.clr = clr;
        r.frame = f; r.fv = fv; r.se = se; r.ov = ov; r.drop = dr; r.fc = fc;
        return r;
    endfunction

    initial begin
        int ring;
        clear = 0; phase = '0; din = '0; din_valid = 0; err_clr = 0; frame_ready = 0;
        mdl_reset();

        // Reset state, checked while clear is held low.
        #3;
        chk("reset frame", frame, 32'h0);
        chk("reset fv", frame_valid, 32'h0);
        chk("reset flags", {seq_err, overrun}, 32'h0);
        chk("reset counters", {drop_cnt, frame_cnt}, 32'h0);

        // rst ph din v rdy clr | frame fv se ov drop fc
        // Single frame delivered with ready high. Then a missing slot0 sample aborts.
        tbl.push_back(mk(1, 4'h1, 8'h11, 1, 1, 0, 32'h0,        0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h2, 8'h22, 1, 1, 0, 32'h0,        0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h4, 8'h33, 1, 1, 0, 32'h0,        0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h8, 8'h44, 1, 1, 0, 32'h44332211, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h1, 8'h00, 0, 1, 0, 32'h44332211, 0, 0, 0, 1, 1));
        // Back-to-back frames with ready low: overrun, frame held, err_clr, then drain.
        tbl.push_back(mk(1, 4'h1, 8'hAA, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h2, 8'hBB, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h4, 8'hCC, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h8, 8'hDD, 1, 0, 0, 32'hDDCCBBAA, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h1, 8'h01, 1, 0, 0, 32'hDDCCBBAA, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h2, 8'h02, 1, 0, 0, 32'hDDCCBBAA, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h4, 8'h03, 1, 0, 0, 32'hDDCCBBAA, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h8, 8'h04, 1, 0, 0, 32'hDDCCBBAA, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'h1, 8'h00, 0, 0, 1, 32'hDDCCBBAA, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4'h2, 8'h00, 0, 1, 0, 32'hDDCCBBAA, 0, 0, 0, 1, 1));
        // Out-of-order phase 0001 -> 0100, then a clean frame. A new error beats err_clr.
        tbl.push_back(mk(1, 4'h1, 8'h10, 1, 1, 0, 32'h0,        0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h4, 8'h20, 1, 1, 0, 32'h0,        0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 4'h8, 8'h30, 1, 1, 0, 32'h0,        0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 4'h1, 8'h55, 1, 1, 0, 32'h0,        0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 4'h2, 8'h66, 1, 1, 0, 32'h0,        0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 4'h4, 8'h77, 1, 1, 0, 32'h0,        0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 4'h8, 8'h88, 1, 1, 0, 32'h88776655, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 4'h2, 8'h00, 0, 1, 1, 32'h88776655, 0, 1, 0, 2, 1));
        tbl.push_back(mk(0, 4'h1, 8'h00, 0, 1, 1, 32'h88776655, 0, 0, 0, 2, 1));
        // Missing sample in slot2 aborts without seq_err. The next clean rotation delivers.
        tbl.push_back(mk(1, 4'h1, 8'hA1, 1, 1, 0, 32'h0,        0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h2, 8'hA2, 1, 1, 0, 32'h0,        0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h4, 8'hA3, 0, 1, 0, 32'h0,        0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4'h8, 8'hA4, 1, 1, 0, 32'h0,        0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4'h1, 8'hB1, 1, 1, 0, 32'h0,        0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4'h2, 8'hB2, 1, 1, 0, 32'h0,        0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4'h4, 8'hB3, 1, 1, 0, 32'h0,        0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4'h8, 8'hB4, 1, 1, 0, 32'hB4B3B2B1, 1, 0, 0, 1, 0));
        // Illegal codes: ignored in SYNC, flagged while collecting.
        tbl.push_back(mk(1, 4'h3, 8'h05, 1, 1, 0, 32'h0,        0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 8'h06, 1, 1, 0, 32'h0,        0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h1, 8'hC1, 1, 1, 0, 32'h0,        0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h3, 8'hC2, 1, 1, 0, 32'h0,        0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 4'h1, 8'hD1, 1, 1, 0, 32'h0,        0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 4'h0, 8'hD2, 1, 1, 0, 32'h0,        0, 1, 0, 2, 0));
        tbl.push_back(mk(0, 4'hF, 8'hD3, 1, 1, 0, 32'h0,        0, 1, 0, 2, 0));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].ph, tbl[i].din, tbl[i].v, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("vec%0d frame", i),    frame,       tbl[i].frame);
            chk($sformatf("vec%0d fv", i),       frame_valid, 32'(tbl[i].fv));
            chk($sformatf("vec%0d seq_err", i),  seq_err,     32'(tbl[i].se));
            chk($sformatf("vec%0d overrun", i),  overrun,     32'(tbl[i].ov));
            chk($sformatf("vec%0d drop", i),     drop_cnt,    tbl[i].drop);
            chk($sformatf("vec%0d fcnt", i),     frame_cnt,   fc_exp(tbl[i].fc));
            @(negedge clk);
        end

        // Asynchronous clear in the middle of a frame, with nonzero state beforehand.
        do_reset();
        step(4'h1, 8'hAA, 1, 0, 0); @(negedge clk);
        step(4'h2, 8'hBB, 1, 0, 0); @(negedge clk);
        step(4'h4, 8'hCC, 1, 0, 0); @(negedge clk);
        step(4'h8, 8'hDD, 1, 0, 0); @(negedge clk);
        step(4'h4, 8'h00, 1, 0, 0); @(negedge clk);
        step(4'h1, 8'hE1, 1, 0, 0); @(negedge clk);
        chk_model("preclear");
        phase = 4'h2; din = 8'hE2; din_valid = 1;
        #2 clear = 0;
        #1;
        chk("async frame", frame, 32'h0);
        chk("async fv", frame_valid, 32'h0);
        chk("async flags", {seq_err, overrun}, 32'h0);
        chk("async counters", {drop_cnt, frame_cnt}, 32'h0);
        phase = '0; din_valid = 0;
        #1 clear = 1;
        mdl_reset();
        @(negedge clk);
        step(4'h1, 8'h12, 1, 1, 0); @(negedge clk);
        step(4'h2, 8'h34, 1, 1, 0); @(negedge clk);
        step(4'h4, 8'h56, 1, 1, 0); @(negedge clk);
        step(4'h8, 8'h78, 1, 1, 0);
        chk("postclear frame", frame, 32'h78563412);
        chk("postclear fv", frame_valid, 32'h1);
        @(negedge clk);

        // Randomized run: mostly a rotating token with occasional corrupt codes,
        // dropped samples, back-pressure and err_clr pulses.
        do_reset();
        ring = 0;
        for (int c = 0; c < 4000; c++) begin
            logic [3:0] ph;
            ph = (4'b0001 << ring);
            if ($urandom_range(0, 99) < 12) ph = 4'($urandom_range(0, 15));
            step(ph, 8'($urandom), ($urandom_range(0, 99) < 92),
                 ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 4));
            chk_model($sformatf("rnd%0d", c));
            @(negedge clk);
            ring = (ring + 1) % 4;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
